// File: rtl/faux_hd_command_engine.sv
`default_nettype none
// ============================================================================
// faux_hd_command_engine
//   Simulated SATA device command layer. It answers READ/WRITE DMA EXT in
//   multi-FIS chunks and reports errors with the matching ATA status/error.
//   Revision: 1.0
// ============================================================================
module faux_hd_command_engine #(
   parameter int SLEEP_LENGTH    = 100,
   parameter int SECTOR_DWORDS   = 128,
   parameter int MAX_FIS_SECTORS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        transport_layer_ready,
   input  logic        h2d_reg_stb,
   input  logic        h2d_data_stb,
   input  logic        h2d_cmd_bit,
   input  logic [7:0]  h2d_command,
   input  logic [7:0]  h2d_control,
   input  logic [47:0] h2d_lba,
   input  logic [15:0] h2d_sector_count,
   input  logic        of_strobe,
   input  logic        xmit_error,
   input  logic        read_crc_fail,
   output logic        command_layer_ready,
   output logic        command_layer_busy,
   output logic        send_reg_stb,
   output logic        send_dma_act_stb,
   output logic        send_data_stb,
   output logic [11:0] data_fis_dwords,
   output logic [7:0]  d2h_status,
   output logic [7:0]  d2h_error,
   output logic        d2h_interrupt,
   output logic [47:0] d2h_lba,
   output logic [15:0] d2h_sector_count,
   output logic [16:0] sectors_done,
   output logic [3:0]  cl_state
);

   localparam int SLEEP_W = $clog2(SLEEP_LENGTH + 1);
   localparam int DW_W    = (SECTOR_DWORDS > 1) ? $clog2(SECTOR_DWORDS) : 1;

   localparam logic [3:0] SLEEP_START = 4'd0;
   localparam logic [3:0] SEND_DIAG   = 4'd1;
   localparam logic [3:0] IDLE        = 4'd2;
   localparam logic [3:0] DMA_ACT     = 4'd3;
   localparam logic [3:0] WRITE_DATA  = 4'd4;
   localparam logic [3:0] SEND_DATA   = 4'd5;
   localparam logic [3:0] READ_WAIT   = 4'd6;
   localparam logic [3:0] SEND_STATUS = 4'd7;
   localparam logic [3:0] SEND_ERROR  = 4'd8;

   localparam logic [7:0] CMD_READ_DMA_EXT  = 8'h25;
   localparam logic [7:0] CMD_WRITE_DMA_EXT = 8'h35;

   logic [3:0]         state;
   logic [SLEEP_W-1:0] sleep_cnt;
   logic [16:0]        total;
   logic [DW_W-1:0]    dword_cnt;
   logic               seen_low;

   logic        srst;
   logic        link_err;
   logic [16:0] remaining;
   logic [16:0] chunk;
   logic        sector_tick;
   logic [16:0] done_after;
   logic        unused_control;

   assign srst           = h2d_control[2];
   assign unused_control = ^{h2d_control[7:3], h2d_control[1:0]};
   assign link_err       = xmit_error | read_crc_fail;
   assign remaining      = total - sectors_done;
   assign chunk          = (remaining > 17'(MAX_FIS_SECTORS)) ? 17'(MAX_FIS_SECTORS) : remaining;
   assign sector_tick    = of_strobe && (dword_cnt == DW_W'(SECTOR_DWORDS - 1));
   assign done_after     = sectors_done + (sector_tick ? 17'd1 : 17'd0);

   assign command_layer_ready = (state == IDLE);
   assign command_layer_busy  = ~command_layer_ready;
   assign cl_state            = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= SLEEP_START;
         sleep_cnt        <= '0;
         total            <= '0;
         dword_cnt        <= '0;
         seen_low         <= 1'b0;
         send_reg_stb     <= 1'b0;
         send_dma_act_stb <= 1'b0;
         send_data_stb    <= 1'b0;
         data_fis_dwords  <= '0;
         d2h_status       <= 8'h50;
         d2h_error        <= 8'h01;
         d2h_interrupt    <= 1'b0;
         d2h_lba          <= 48'd1;
         d2h_sector_count <= 16'd1;
         sectors_done     <= '0;
      end else begin
         send_reg_stb     <= 1'b0;
         send_dma_act_stb <= 1'b0;
         send_data_stb    <= 1'b0;
         if (srst) begin
            state     <= SLEEP_START;
            sleep_cnt <= '0;
            seen_low  <= 1'b0;
         end else begin
            case (state)
               SLEEP_START: begin
                  if (sleep_cnt == SLEEP_W'(SLEEP_LENGTH)) begin
                     state <= SEND_DIAG;
                  end else begin
                     sleep_cnt <= sleep_cnt + SLEEP_W'(1);
                  end
               end
               SEND_DIAG: begin
                  // Diagnostic signature is re-issued after every soft reset too
                  d2h_status       <= 8'h50;
                  d2h_error        <= 8'h01;
                  d2h_interrupt    <= 1'b0;
                  d2h_lba          <= 48'd1;
                  d2h_sector_count <= 16'd1;
                  send_reg_stb     <= 1'b1;
                  state            <= IDLE;
               end
               IDLE: begin
                  if (h2d_reg_stb && h2d_cmd_bit) begin
                     d2h_lba          <= h2d_lba;
                     d2h_sector_count <= h2d_sector_count;
                     total            <= (h2d_sector_count == 16'd0) ? 17'h10000 : {1'b0, h2d_sector_count};
                     sectors_done     <= '0;
                     dword_cnt        <= '0;
                     d2h_interrupt    <= 1'b0;
                     if (h2d_command == CMD_READ_DMA_EXT) begin
                        state <= SEND_DATA;
                     end else if (h2d_command == CMD_WRITE_DMA_EXT) begin
                        state <= DMA_ACT;
                     end else begin
                        d2h_status <= 8'h51;
                        d2h_error  <= 8'h04;
                        state      <= SEND_ERROR;
                     end
                  end
               end
               SEND_DATA: begin
                  if (link_err) begin
                     d2h_status <= 8'h51;
                     d2h_error  <= 8'h84;
                     state      <= SEND_ERROR;
                  end else if (transport_layer_ready) begin
                     data_fis_dwords <= 12'(chunk * 17'(SECTOR_DWORDS));
                     send_data_stb   <= 1'b1;
                     sectors_done    <= sectors_done + chunk;
                     seen_low        <= 1'b0;
                     state           <= READ_WAIT;
                  end
               end
               READ_WAIT: begin
                  // The transport must visibly go busy before its idle means "FIS sent"
                  if (link_err) begin
                     d2h_status <= 8'h51;
                     d2h_error  <= 8'h84;
                     state      <= SEND_ERROR;
                  end else if (!transport_layer_ready) begin
                     seen_low <= 1'b1;
                  end else if (seen_low) begin
                     state <= (sectors_done < total) ? SEND_DATA : SEND_STATUS;
                  end
               end
               DMA_ACT: begin
                  if (link_err) begin
                     d2h_status <= 8'h51;
                     d2h_error  <= 8'h84;
                     state      <= SEND_ERROR;
                  end else if (transport_layer_ready) begin
                     send_dma_act_stb <= 1'b1;
                     state            <= WRITE_DATA;
                  end
               end
               WRITE_DATA: begin
                  if (link_err) begin
                     d2h_status <= 8'h51;
                     d2h_error  <= 8'h84;
                     state      <= SEND_ERROR;
                  end else begin
                     // A partial sector at the end of a FIS carries into the next one
                     if (of_strobe) begin
                        dword_cnt    <= sector_tick ? '0 : dword_cnt + DW_W'(1);
                        sectors_done <= done_after;
                     end
                     if (h2d_data_stb) begin
                        state <= (done_after >= total) ? SEND_STATUS : DMA_ACT;
                     end
                  end
               end
               SEND_STATUS: begin
                  if (transport_layer_ready) begin
                     d2h_status    <= 8'h50;
                     d2h_error     <= 8'h00;
                     d2h_interrupt <= 1'b1;
                     send_reg_stb  <= 1'b1;
                     state         <= IDLE;
                  end
               end
               SEND_ERROR: begin
                  if (transport_layer_ready) begin
                     d2h_interrupt <= 1'b1;
                     send_reg_stb  <= 1'b1;
                     state         <= IDLE;
                  end
               end
               default: begin
                  state     <= SLEEP_START;
                  sleep_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_faux_hd_command_engine.sv
`default_nettype none
// ============================================================================
// tb_faux_hd_command_engine
//   Directed checks of diagnostic, read/write chunking, soft reset and errors.
//   Revision: 1.0
// ============================================================================
module tb_faux_hd_command_engine;

   localparam int SLEEP_LENGTH = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        transport_layer_ready = 1'b1;
   logic        h2d_reg_stb = 1'b0;
   logic        h2d_data_stb = 1'b0;
   logic        h2d_cmd_bit = 1'b0;
   logic [7:0]  h2d_command = 8'h00;
   logic [7:0]  h2d_control = 8'h00;
   logic [47:0] h2d_lba = 48'd0;
   logic [15:0] h2d_sector_count = 16'd0;
   logic        of_strobe = 1'b0;
   logic        xmit_error = 1'b0;
   logic        read_crc_fail = 1'b0;
   logic        command_layer_ready;
   logic        command_layer_busy;
   logic        send_reg_stb;
   logic        send_dma_act_stb;
   logic        send_data_stb;
   logic [11:0] data_fis_dwords;
   logic [7:0]  d2h_status;
   logic [7:0]  d2h_error;
   logic        d2h_interrupt;
   logic [47:0] d2h_lba;
   logic [15:0] d2h_sector_count;
   logic [16:0] sectors_done;
   logic [3:0]  cl_state;

   int vectors = 0;
   int miscompares = 0;
   int n_reg = 0;
   int n_dma = 0;
   int n_data = 0;

   faux_hd_command_engine #(
      .SLEEP_LENGTH(SLEEP_LENGTH),
      .SECTOR_DWORDS(128),
      .MAX_FIS_SECTORS(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .transport_layer_ready(transport_layer_ready),
      .h2d_reg_stb(h2d_reg_stb),
      .h2d_data_stb(h2d_data_stb),
      .h2d_cmd_bit(h2d_cmd_bit),
      .h2d_command(h2d_command),
      .h2d_control(h2d_control),
      .h2d_lba(h2d_lba),
      .h2d_sector_count(h2d_sector_count),
      .of_strobe(of_strobe),
      .xmit_error(xmit_error),
      .read_crc_fail(read_crc_fail),
      .command_layer_ready(command_layer_ready),
      .command_layer_busy(command_layer_busy),
      .send_reg_stb(send_reg_stb),
      .send_dma_act_stb(send_dma_act_stb),
      .send_data_stb(send_data_stb),
      .data_fis_dwords(data_fis_dwords),
      .d2h_status(d2h_status),
      .d2h_error(d2h_error),
      .d2h_interrupt(d2h_interrupt),
      .d2h_lba(d2h_lba),
      .d2h_sector_count(d2h_sector_count),
      .sectors_done(sectors_done),
      .cl_state(cl_state)
   );

   always #5 clk = ~clk;

   // Pulse counters: pre-edge values are read, so a pulse is counted one edge late
   always @(posedge clk) begin
      if (send_reg_stb)     n_reg  <= n_reg + 1;
      if (send_dma_act_stb) n_dma  <= n_dma + 1;
      if (send_data_stb)    n_data <= n_data + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pulse(input int which, input int budget, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         case (which)
            0:       got = send_reg_stb;
            1:       got = send_dma_act_stb;
            default: got = send_data_stb;
         endcase
      end
      check(tag, {63'd0, got}, 64'd1);
   endtask

   task automatic issue_cmd(input logic [7:0] cmd, input logic [15:0] cnt, input logic cbit);
      h2d_reg_stb      = 1'b1;
      h2d_cmd_bit      = cbit;
      h2d_command      = cmd;
      h2d_sector_count = cnt;
      h2d_lba          = 48'h0000_1234_5678;
      @(negedge clk);
      h2d_reg_stb      = 1'b0;
      h2d_cmd_bit      = 1'b0;
   endtask

   task automatic write_dwords(input int n, input bit end_fis);
      for (int i = 0; i < n; i++) begin
         of_strobe    = 1'b1;
         h2d_data_stb = end_fis && (i == n - 1);
         @(negedge clk);
      end
      of_strobe    = 1'b0;
      h2d_data_stb = 1'b0;
   endtask

   task automatic wait_diag();
      wait_pulse(0, SLEEP_LENGTH + 20, "diag_reg_stb");
      check("diag_status", 64'(d2h_status), 64'h50);
      check("diag_error", 64'(d2h_error), 64'h01);
      @(negedge clk);
   endtask

   initial begin
      int first_seen;
      int base_reg, base_dma, base_data;
      logic [11:0] exp_len [3];
      exp_len[0] = 12'd2048;
      exp_len[1] = 12'd2048;
      exp_len[2] = 12'd1024;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_state", 64'(cl_state), 64'd0);
      check("rst_status", 64'(d2h_status), 64'h50);
      check("rst_error", 64'(d2h_error), 64'h01);
      check("rst_lba", 64'(d2h_lba), 64'd1);
      check("rst_count", 64'(d2h_sector_count), 64'd1);
      check("rst_fis_len", 64'(data_fis_dwords), 64'd0);
      check("rst_busy", 64'(command_layer_busy), 64'd1);

      // 1: diagnostic FIS exactly SLEEP_LENGTH+2 edges after reset release
      rst = 1'b0;
      first_seen = -1;
      for (int n = 1; n <= SLEEP_LENGTH + 12; n++) begin
         @(negedge clk);
         if (send_reg_stb && first_seen < 0) first_seen = n;
      end
      check("diag_latency", 64'(first_seen), 64'(SLEEP_LENGTH + 2));
      check("diag_once", 64'(n_reg), 64'd1);
      check("diag_status", 64'(d2h_status), 64'h50);
      check("diag_error", 64'(d2h_error), 64'h01);
      check("idle_state", 64'(cl_state), 64'd2);
      check("idle_ready", 64'(command_layer_ready), 64'd1);

      // Register FIS without C bit is ignored
      issue_cmd(8'h25, 16'd4, 1'b0);
      @(negedge clk);
      check("nocbit_state", 64'(cl_state), 64'd2);

      // 2: READ 40 sectors -> 2048, 2048, 1024 dwords
      base_data = n_data;
      issue_cmd(8'h25, 16'd40, 1'b1);
      for (int k = 0; k < 3; k++) begin
         wait_pulse(2, 20, "rd_data_stb");
         check("rd_fis_len", 64'(data_fis_dwords), 64'(exp_len[k]));
         transport_layer_ready = 1'b0;
         repeat (2) @(negedge clk);
         transport_layer_ready = 1'b1;
      end
      wait_pulse(0, 20, "rd_status_stb");
      check("rd_status", 64'(d2h_status), 64'h50);
      check("rd_error", 64'(d2h_error), 64'h00);
      check("rd_irq", 64'(d2h_interrupt), 64'd1);
      check("rd_sectors", 64'(sectors_done), 64'd40);
      check("rd_lba", 64'(d2h_lba), 64'h0000_1234_5678);
      check("rd_count", 64'(d2h_sector_count), 64'd40);
      @(negedge clk);
      check("rd_nfis", 64'(n_data - base_data), 64'd3);

      // 3: WRITE 3 sectors over 256 + 128 dwords
      base_dma = n_dma;
      issue_cmd(8'h35, 16'd3, 1'b1);
      wait_pulse(1, 20, "wr_dma1");
      write_dwords(256, 1'b1);
      check("wr_mid_sectors", 64'(sectors_done), 64'd2);
      wait_pulse(1, 20, "wr_dma2");
      write_dwords(128, 1'b1);
      wait_pulse(0, 20, "wr_status_stb");
      check("wr_sectors", 64'(sectors_done), 64'd3);
      check("wr_status", 64'(d2h_status), 64'h50);
      check("wr_irq", 64'(d2h_interrupt), 64'd1);
      @(negedge clk);
      check("wr_ndma", 64'(n_dma - base_dma), 64'd2);

      // 4a: READ count 0 -> first chunk 2048 dwords, SRST while waiting
      issue_cmd(8'h25, 16'd0, 1'b1);
      wait_pulse(2, 20, "rd0_data_stb");
      check("rd0_fis_len", 64'(data_fis_dwords), 64'd2048);
      check("rd0_count", 64'(d2h_sector_count), 64'd0);
      base_reg = n_reg;
      h2d_control = 8'h04;
      repeat (2) @(negedge clk);
      check("srst_state", 64'(cl_state), 64'd0);
      h2d_control = 8'h00;
      wait_diag();
      check("srst_one_fis", 64'(n_reg - base_reg), 64'd1);

      // 4b: WRITE count 0 -> 65536 sectors, abort with SRST mid-transfer
      base_reg = n_reg;
      base_dma = n_dma;
      issue_cmd(8'h35, 16'd0, 1'b1);
      wait_pulse(1, 20, "wr0_dma");
      write_dwords(200, 1'b0);
      check("wr0_sectors", 64'(sectors_done), 64'd1);
      check("wr0_state", 64'(cl_state), 64'd4);
      h2d_control = 8'h04;
      repeat (3) @(negedge clk);
      check("wr0_srst_state", 64'(cl_state), 64'd0);
      check("wr0_no_fis", 64'(n_reg - base_reg), 64'd0);
      h2d_control = 8'h00;
      wait_diag();
      check("wr0_dma_once", 64'(n_dma - base_dma), 64'd1);

      // 5: CRC failure during WRITE_DATA
      issue_cmd(8'h35, 16'd2, 1'b1);
      wait_pulse(1, 20, "crc_dma");
      write_dwords(10, 1'b0);
      read_crc_fail = 1'b1;
      @(negedge clk);
      read_crc_fail = 1'b0;
      wait_pulse(0, 20, "crc_reg_stb");
      check("crc_status", 64'(d2h_status), 64'h51);
      check("crc_error", 64'(d2h_error), 64'h84);
      check("crc_irq", 64'(d2h_interrupt), 64'd1);
      @(negedge clk);
      check("crc_idle", 64'(cl_state), 64'd2);

      // 6: unknown opcode aborts without data or DMA activate
      base_dma  = n_dma;
      base_data = n_data;
      issue_cmd(8'hEC, 16'd1, 1'b1);
      wait_pulse(0, 20, "abrt_reg_stb");
      check("abrt_status", 64'(d2h_status), 64'h51);
      check("abrt_error", 64'(d2h_error), 64'h04);
      check("abrt_irq", 64'(d2h_interrupt), 64'd1);
      repeat (2) @(negedge clk);
      check("abrt_no_dma", 64'(n_dma - base_dma), 64'd0);
      check("abrt_no_data", 64'(n_data - base_data), 64'd0);
      check("abrt_idle", 64'(cl_state), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
